// File: rtl/onebc_runctl.sv
// Run-control sequencer for the 1-bit computer core: boot reset, halt/run/step, PC breakpoint, executed-cycle count.
// Optional PC trace buffer enabled by defining ONEBC_TRACE_EN.
module onebc_runctl #(
  parameter int CNT_W       = 16,
  parameter int RST_CYCLES  = 2,
  parameter int TRACE_DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  input  logic             halt_i,
  input  logic             step_i,
  input  logic             reboot_i,
  input  logic             bp_en_i,
  input  logic [7:0]       bp_adr_i,
  input  logic [7:0]       pc_i,
  output logic             core_rst_o,
  output logic             core_en_o,
  output logic             halted_o,
  output logic             bp_hit_o,
  output logic [CNT_W-1:0] cyc_cnt_o,
  output logic [1:0]       state_o
`ifdef ONEBC_TRACE_EN
  ,
  input  logic             trace_rd_i,
  output logic             trace_vld_o,
  output logic [7:0]       trace_pc_o
`endif
);

  localparam int BCNT_W = $clog2(RST_CYCLES + 1);

  typedef enum logic [1:0] {
    S_BOOT = 2'b00,
    S_HALT = 2'b01,
    S_RUN  = 2'b10,
    S_STEP = 2'b11
  } state_t;

  if (RST_CYCLES < 1) begin : g_rst_cycles_chk
    $error("RST_CYCLES must be at least 1");
  end
  if (TRACE_DEPTH < 2 || (TRACE_DEPTH & (TRACE_DEPTH - 1)) != 0) begin : g_trace_depth_chk
    $error("TRACE_DEPTH must be a power of 2 and at least 2");
  end

  state_t            state, state_nxt;
  logic [BCNT_W-1:0] boot_cnt;
  logic              skip;
  logic              bp_match;
  logic              core_en;
  logic              bp_set, bp_clr, skip_set, skip_clr, boot_clr;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_BOOT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    core_en   = 1'b0;
    bp_set    = 1'b0;
    bp_clr    = 1'b0;
    skip_set  = 1'b0;
    skip_clr  = 1'b0;
    boot_clr  = 1'b0;
    // skip masks the breakpoint on the first RUN cycle so a resume at bp_adr executes it once
    bp_match  = (state == S_RUN) && bp_en_i && (pc_i == bp_adr_i) && !skip;
    case (state)
      S_BOOT: begin
        if (boot_cnt == BCNT_W'(RST_CYCLES - 1)) state_nxt = S_HALT;
      end
      S_HALT: begin
        if (halt_i) begin
          state_nxt = S_HALT;
        end else if (step_i) begin
          state_nxt = S_STEP;
          bp_clr    = 1'b1;
          skip_set  = 1'b1;
        end else if (run_i) begin
          state_nxt = S_RUN;
          bp_clr    = 1'b1;
          skip_set  = 1'b1;
        end
      end
      S_RUN: begin
        core_en  = !bp_match;
        skip_clr = 1'b1;
        if (bp_match) begin
          state_nxt = S_HALT;
          bp_set    = 1'b1;
        end else if (halt_i) begin
          state_nxt = S_HALT;
        end
      end
      S_STEP: begin
        core_en   = 1'b1;
        skip_clr  = 1'b1;
        state_nxt = S_HALT;
      end
      default: state_nxt = S_BOOT;
    endcase
    if (reboot_i) begin
      state_nxt = S_BOOT;
      boot_clr  = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      boot_cnt  <= '0;
      cyc_cnt_o <= '0;
      bp_hit_o  <= 1'b0;
      skip      <= 1'b0;
    end else begin
      if (boot_clr || state != S_BOOT) boot_cnt <= '0;
      else                              boot_cnt <= boot_cnt + 1'b1;

      if (boot_clr)                          cyc_cnt_o <= '0;
      else if (core_en && cyc_cnt_o != '1)   cyc_cnt_o <= cyc_cnt_o + 1'b1;

      if (boot_cnt != boot_cnt || boot_clr || bp_clr) bp_hit_o <= 1'b0;
      else if (bp_set)                                bp_hit_o <= 1'b1;

      if (skip_set)      skip <= 1'b1;
      else if (skip_clr) skip <= 1'b0;
    end
  end

  assign core_en_o  = core_en;
  assign core_rst_o = (state == S_BOOT);
  assign halted_o   = (state == S_HALT);
  assign state_o    = state;

`ifdef ONEBC_TRACE_EN
  localparam int TP_W = $clog2(TRACE_DEPTH);

  logic [7:0]      trace_mem [TRACE_DEPTH];
  logic [TP_W-1:0] wr_ptr, rd_ptr;
  logic [TP_W:0]   trace_cnt;
  logic            trace_full, trace_pop;

  assign trace_full = (trace_cnt == (TP_W + 1)'(TRACE_DEPTH));
  assign trace_pop  = trace_rd_i && (state == S_HALT) && (trace_cnt != '0);

  // Writes only happen with core_en (never in HALT), so a pop and a push never coincide
  always_ff @(posedge clk_i) begin
    if (rst_i || state_nxt == S_BOOT) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      trace_cnt <= '0;
    end else if (core_en) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (trace_full) rd_ptr    <= rd_ptr + 1'b1;
      else            trace_cnt <= trace_cnt + 1'b1;
    end else if (trace_pop) begin
      rd_ptr    <= rd_ptr + 1'b1;
      trace_cnt <= trace_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (core_en) trace_mem[wr_ptr] <= pc_i;
  end

  assign trace_vld_o = (trace_cnt != '0);
  assign trace_pc_o  = trace_mem[rd_ptr];
`endif

endmodule

// File: tb/tb_onebc_runctl.sv
// Scoreboard bench for onebc_runctl: per-cycle expected output vectors queued at drive time and compared mid-cycle.
module tb_onebc_runctl;

  localparam logic [1:0] BOOT = 2'b00, HALT = 2'b01, RUN = 2'b10, STEP = 2'b11;
  localparam logic [3:0] C_NONE = 4'b0000, C_STEP = 4'b0001, C_HALT = 4'b0010,
                         C_RUN = 4'b0100, C_REBOOT = 4'b1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_i = 1'b1, run_i = 1'b0, halt_i = 1'b0, step_i = 1'b0, reboot_i = 1'b0;
  logic       bp_en_i = 1'b0;
  logic [7:0] bp_adr_i = 8'h00, pc_i = 8'h00;
  logic       core_rst_o, core_en_o, halted_o, bp_hit_o;
  logic [3:0] cyc_cnt_o;
  logic [1:0] state_o;
`ifdef ONEBC_TRACE_EN
  logic       trace_rd_i = 1'b0;
  logic       trace_vld_o;
  logic [7:0] trace_pc_o;
`endif

  onebc_runctl #(.CNT_W(4), .RST_CYCLES(2), .TRACE_DEPTH(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .run_i(run_i), .halt_i(halt_i), .step_i(step_i),
    .reboot_i(reboot_i), .bp_en_i(bp_en_i), .bp_adr_i(bp_adr_i), .pc_i(pc_i),
    .core_rst_o(core_rst_o), .core_en_o(core_en_o), .halted_o(halted_o),
    .bp_hit_o(bp_hit_o), .cyc_cnt_o(cyc_cnt_o), .state_o(state_o)
`ifdef ONEBC_TRACE_EN
    , .trace_rd_i(trace_rd_i), .trace_vld_o(trace_vld_o), .trace_pc_o(trace_pc_o)
`endif
  );

  // observed vector: {core_rst, core_en, halted, bp_hit, state[1:0], cyc_cnt[3:0]}
  logic [9:0] obs;
  assign obs = {core_rst_o, core_en_o, halted_o, bp_hit_o, state_o, cyc_cnt_o};

  int         checks = 0;
  int         errors = 0;
  logic [9:0] exp_q[$];

  function automatic logic [9:0] ex(input logic r, input logic e, input logic h, input logic b,
                                    input logic [1:0] s, input logic [3:0] c);
    return {r, e, h, b, s, c};
  endfunction

  task automatic drv(input logic [3:0] cmd, input logic bpe, input logic [7:0] adr,
                     input logic [7:0] pc);
    @(negedge clk);
    {reboot_i, run_i, halt_i, step_i} = cmd;
    bp_en_i  = bpe;
    bp_adr_i = adr;
    pc_i     = pc;
  endtask

  task automatic test_reset;
    logic [9:0] ev;
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    exp_q.push_back(ex(1, 0, 0, 0, BOOT, 0));
    #1;
    ev = exp_q.pop_front();
    checks++;
    if (obs !== ev) begin
      errors++;
      $display("FAIL reset_hold: got %b expected %b", obs, ev);
    end
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drv(C_NONE, 1'b0, 8'h00, 8'h00);
      exp_q.push_back((i == 0) ? ex(1, 0, 0, 0, BOOT, 0) : ex(0, 0, 1, 0, HALT, 0));
      #1;
      ev = exp_q.pop_front();
      checks++;
      if (obs !== ev) begin
        errors++;
        $display("FAIL reset[%0d]: got %b expected %b", i, obs, ev);
      end
    end
  endtask

  task automatic test_step;
    logic [3:0] cm[8];
    logic [9:0] e[8];
    logic [9:0] ev;
    cm = '{C_STEP, C_NONE, C_NONE, C_STEP | C_RUN, C_NONE, C_NONE, C_HALT | C_STEP, C_NONE};
    e  = '{ex(0, 0, 1, 0, HALT, 0), ex(0, 1, 0, 0, STEP, 0), ex(0, 0, 1, 0, HALT, 1),
           ex(0, 0, 1, 0, HALT, 1), ex(0, 1, 0, 0, STEP, 1), ex(0, 0, 1, 0, HALT, 2),
           ex(0, 0, 1, 0, HALT, 2), ex(0, 0, 1, 0, HALT, 2)};
    for (int i = 0; i < 8; i++) begin
      drv(cm[i], 1'b0, 8'h00, 8'h10);
      exp_q.push_back(e[i]);
      #1;
      ev = exp_q.pop_front();
      checks++;
      if (obs !== ev) begin
        errors++;
        $display("FAIL step[%0d]: got %b expected %b", i, obs, ev);
      end
    end
  endtask

  task automatic test_breakpoint;
    logic [3:0] cm[5];
    logic [7:0] pc[5];
    logic [9:0] e[5];
    logic [9:0] ev;
    cm = '{C_RUN, C_NONE, C_NONE, C_NONE, C_NONE};
    pc = '{8'h03, 8'h03, 8'h04, 8'h05, 8'h05};
    e  = '{ex(0, 0, 1, 0, HALT, 2), ex(0, 1, 0, 0, RUN, 2), ex(0, 1, 0, 0, RUN, 3),
           ex(0, 0, 0, 0, RUN, 4), ex(0, 0, 1, 1, HALT, 4)};
    for (int i = 0; i < 5; i++) begin
      drv(cm[i], 1'b1, 8'h05, pc[i]);
      exp_q.push_back(e[i]);
      #1;
      ev = exp_q.pop_front();
      checks++;
      if (obs !== ev) begin
        errors++;
        $display("FAIL breakpoint[%0d]: got %b expected %b", i, obs, ev);
      end
    end
  endtask

  task automatic test_resume;
    logic [3:0] cm[8];
    logic [7:0] pc[8];
    logic [9:0] e[8];
    logic [9:0] ev;
    cm = '{C_RUN, C_NONE, C_HALT, C_NONE, C_RUN, C_NONE, C_HALT, C_NONE};
    pc = '{8'h05, 8'h05, 8'h06, 8'h06, 8'h07, 8'h07, 8'h05, 8'h05};
    e  = '{ex(0, 0, 1, 1, HALT, 4), ex(0, 1, 0, 0, RUN, 4), ex(0, 1, 0, 0, RUN, 5),
           ex(0, 0, 1, 0, HALT, 6), ex(0, 0, 1, 0, HALT, 6), ex(0, 1, 0, 0, RUN, 6),
           ex(0, 0, 0, 0, RUN, 7), ex(0, 0, 1, 1, HALT, 7)};
    for (int i = 0; i < 8; i++) begin
      drv(cm[i], 1'b1, 8'h05, pc[i]);
      exp_q.push_back(e[i]);
      #1;
      ev = exp_q.pop_front();
      checks++;
      if (obs !== ev) begin
        errors++;
        $display("FAIL resume[%0d]: got %b expected %b", i, obs, ev);
      end
    end
  endtask

  task automatic test_saturation;
    logic [9:0] ev;
    int         c;
    drv(C_RUN, 1'b0, 8'h05, 8'h00);
    exp_q.push_back(ex(0, 0, 1, 1, HALT, 7));
    for (int k = 0; k < 20; k++) begin
      c = (7 + k > 15) ? 15 : 7 + k;
      exp_q.push_back(ex(0, 1, 0, 0, RUN, 4'(c)));
    end
    exp_q.push_back(ex(0, 1, 0, 0, RUN, 15));
    exp_q.push_back(ex(1, 0, 0, 0, BOOT, 0));
    exp_q.push_back(ex(1, 0, 0, 0, BOOT, 0));
    exp_q.push_back(ex(0, 0, 1, 0, HALT, 0));
    for (int i = 0; i < 25; i++) begin
      if (i > 0)
        drv((i == 21) ? C_REBOOT : C_NONE, 1'b0, 8'h05, 8'(i));
      #1;
      ev = exp_q.pop_front();
      checks++;
      if (obs !== ev) begin
        errors++;
        $display("FAIL saturate[%0d]: got %b expected %b", i, obs, ev);
      end
    end
  endtask

`ifdef ONEBC_TRACE_EN
  task automatic test_trace;
    logic [8:0] tq[$];
    logic [8:0] tev;
    drv(C_NONE, 1'b0, 8'h00, 8'h00);
    #1;
    checks++;
    if (trace_vld_o !== 1'b0) begin
      errors++;
      $display("FAIL trace_empty_after_boot: got vld=%b expected 0", trace_vld_o);
    end
    drv(C_RUN, 1'b0, 8'h00, 8'h00);
    trace_rd_i = 1'b1;
    for (int k = 0; k < 10; k++)
      drv((k == 9) ? C_HALT : C_NONE, 1'b0, 8'h00, 8'(k));
    for (int i = 0; i < 8; i++) tq.push_back({1'b1, 8'(2 + i)});
    tq.push_back({1'b0, trace_pc_o});
    for (int i = 0; i < 9; i++) begin
      drv(C_NONE, 1'b0, 8'h00, 8'h00);
      #1;
      tev = tq.pop_front();
      if (i == 8) tev[7:0] = trace_pc_o;
      checks++;
      if ({trace_vld_o, trace_pc_o} !== tev) begin
        errors++;
        $display("FAIL trace_read[%0d]: got vld=%b pc=%h expected vld=%b pc=%h",
                 i, trace_vld_o, trace_pc_o, tev[8], tev[7:0]);
      end
    end
    trace_rd_i = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_step();
    test_breakpoint();
    test_resume();
    test_saturation();
`ifdef ONEBC_TRACE_EN
    test_trace();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
